// File: rtl/ram_copier.sv
// Streams a block of words from a registered-read source RAM to a destination RAM,
// one word per cycle, with abort and a zero-length fast path.
module ram_copier #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  write_en
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  write_en_q, write_en_d;
    logic                  rvld_q, rvld_d;   // rdata holds a requested word this cycle
    logic                  zpend_q, zpend_d; // zero-length start awaiting its done pulse

    always_comb begin
        state_d    = state_q;
        raddr_d    = raddr_q;
        waddr_d    = waddr_q;
        wptr_d     = wptr_q;
        wdata_d    = wdata_q;
        rem_d      = rem_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        write_en_d = 1'b0;
        rvld_d     = 1'b0;
        zpend_d    = 1'b0;

        if (rvld_q) begin
            write_en_d = 1'b1;
            waddr_d    = wptr_q;
            wdata_d    = rdata;
            wptr_d     = wptr_q + ADDR_WIDTH'(1);
        end

        unique case (state_q)
            StIdle: begin
                done_d = zpend_q;
                if (start) begin
                    if (length != '0) begin
                        state_d = StRun;
                        raddr_d = src_base;
                        wptr_d  = dst_base;
                        rem_d   = length - (ADDR_WIDTH + 1)'(1);
                        busy_d  = 1'b1;
                    end else begin
                        zpend_d = 1'b1;
                    end
                end
            end
            StRun: begin
                rvld_d = 1'b1;
                if (rem_q == '0) begin
                    state_d = StFlush;
                end else begin
                    raddr_d = raddr_q + ADDR_WIDTH'(1);
                    rem_d   = rem_q - (ADDR_WIDTH + 1)'(1);
                end
            end
            StFlush: begin
                if (!rvld_q) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort drops any pending write and returns to idle without a done pulse.
        if (abort && state_q != StIdle) begin
            state_d    = StIdle;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            write_en_d = 1'b0;
            rvld_d     = 1'b0;
            waddr_d    = waddr_q;
            wdata_d    = wdata_q;
            wptr_d     = wptr_q;
            rem_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            raddr_q    <= '0;
            waddr_q    <= '0;
            wptr_q     <= '0;
            wdata_q    <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            write_en_q <= 1'b0;
            rvld_q     <= 1'b0;
            zpend_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            raddr_q    <= raddr_d;
            waddr_q    <= waddr_d;
            wptr_q     <= wptr_d;
            wdata_q    <= wdata_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            write_en_q <= write_en_d;
            rvld_q     <= rvld_d;
            zpend_q    <= zpend_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign raddr    = raddr_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign write_en = write_en_q;

endmodule

// File: doc/ram_copier.md
RAM_COPIER -- requirements
Module: ram_copier

Interface
REQ-001 Parameter ADDR_WIDTH, default 9, address width of source and destination RAM ports.
REQ-002 Parameter DATA_WIDTH, default 8, data width of RAM words.
REQ-003 clk  input  1  single clock; RAM ports driven by this block are clocked by clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request a copy; sampled only in IDLE.
REQ-006 abort  input  1  terminate an active copy.
REQ-007 src_base  input  ADDR_WIDTH  first source address; sampled with start.
REQ-008 dst_base  input  ADDR_WIDTH  first destination address; sampled with start.
REQ-009 length  input  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; sampled with start.
REQ-010 busy  output  1  copy in progress.
REQ-011 done  output  1  one-cycle pulse on normal completion.
REQ-012 raddr  output  ADDR_WIDTH  read address to source RAM.
REQ-013 rdata  input  DATA_WIDTH  source RAM read data, valid one cycle after raddr is presented (registered read).
REQ-014 waddr  output  ADDR_WIDTH  write address to destination RAM.
REQ-015 wdata  output  DATA_WIDTH  write data to destination RAM.
REQ-016 write_en  output  1  write strobe to destination RAM.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 States SHALL be IDLE, RUN and FLUSH. Edge E0 is the edge that samples start=1 in IDLE.
REQ-019 IDLE->RUN on start=1 with length>0. At E0: latch dst_base and length, raddr<=src_base, busy<=1.
REQ-020 RUN: raddr SHALL increment by 1 per edge, so word k is addressed after edge Ek. The last read, k=L-1, is issued after E(L-1). The block SHALL leave RUN for FLUSH at edge EL.
REQ-021 Word k SHALL be written with waddr=dst_base+k, wdata=rdata and write_en=1, all registered at edge E(k+2). Throughput is 1 word/cycle.
REQ-022 FLUSH SHALL last until the write of word L-1 is presented (after E(L+1)). At E(L+2): write_en<=0, busy<=0, done<=1 for exactly one cycle, state IDLE.
REQ-023 busy SHALL be high for exactly L+2 cycles. write_en SHALL be high for exactly L consecutive cycles.
REQ-024 Address arithmetic SHALL be modulo 2^ADDR_WIDTH: raddr and waddr wrap from all-ones to 0.
REQ-025 length=2^ADDR_WIDTH SHALL copy every location once.
REQ-026 length=0 with start: no reads or writes are counted, busy stays 0, and done pulses after E1.
REQ-027 start while busy SHALL be ignored, with no effect on the active copy.
REQ-028 Copy order SHALL be ascending. Results are defined only when the ranges are disjoint, or when dst_base<=src_base in a single shared RAM.
REQ-029 abort=1 while busy (RUN or FLUSH) SHALL, at that edge, set write_en<=0, busy<=0 and state IDLE, with no done pulse. A write already presented in that cycle completes at that edge. No further writes occur.
REQ-030 abort in IDLE SHALL be ignored. abort and start asserted together in IDLE: abort is ignored and the copy starts.
REQ-031 In IDLE, raddr, waddr and wdata SHALL hold their last values, and write_en SHALL be 0.

Reset
REQ-032 rst=1 SHALL immediately, without waiting for clk, force: state IDLE; busy, done and write_en 0; raddr, waddr and wdata 0; internal counters 0.
REQ-033 rst asserted mid-copy SHALL abandon the copy with no further writes and no done pulse. After release, a new start behaves normally.

Verification
REQ-034 src=0x010, dst=0x100, L=4, source holding 0xA0..0xA3 -> write_en high after E2..E5 at 0x100..0x103 with 0xA0..0xA3, done after E6, busy 6 cycles.
REQ-035 src=0x1FE, dst=0x0FE, L=4 -> raddr 0x1FE, 0x1FF, 0x000, 0x001; waddr 0x0FE, 0x0FF, 0x100, 0x101.
REQ-036 L=0 -> no write_en; done pulses one cycle after E1; busy never high.
REQ-037 L=512, src=0, dst=0 on separate RAMs -> 512 writes, busy 514 cycles, destination equals source.
REQ-038 L=8, abort sampled at E4 -> writes of words 0 and 1 only; busy low after E4; no done pulse. A second start after E4 copies correctly.
REQ-039 L=8, rst pulsed between E3 and E4 -> all outputs 0 asynchronously; no further writes; start after release copies 8 words with done.
